// File: rtl/pc_unit.sv
// 6502-style program counter: PCL/PCH in one register with bus loads,
// full-width increment, bus output drivers and relative branch fix-up.
module pc_unit #(
    parameter int                    HALF_W    = 8,
    parameter logic [2*HALF_W-1:0]   RESET_VEC = 16'hFFFC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [HALF_W-1:0] adl_in,
    input  logic [HALF_W-1:0] adh_in,
    input  logic              adl_we,
    input  logic              adh_we,
    input  logic              inc,
    input  logic              br_en,
    input  logic [HALF_W-1:0] br_off,
    input  logic              adl_oe,
    input  logic              adh_oe,
    input  logic              db_oe,
    input  logic              db_sel,
    output logic [HALF_W-1:0] adl_out,
    output logic [HALF_W-1:0] adh_out,
    output logic [HALF_W-1:0] db_out,
    output logic              pcl_carry,
    output logic              page_cross,
    output logic              busy
);

    typedef enum logic {
        IDLE = 1'b0,
        FIX  = 1'b1
    } state_t;

    localparam int              PC_W   = 2 * HALF_W;
    localparam logic [HALF_W-1:0] ONE_H = {{(HALF_W-1){1'b0}}, 1'b1};
    localparam logic [PC_W-1:0]   ONE_F = {{(PC_W-1){1'b0}}, 1'b1};

    state_t            state, state_n;
    logic [HALF_W-1:0] pcl, pcl_n;
    logic [HALF_W-1:0] pch, pch_n;
    logic              dir_up, dir_up_n;

    logic [HALF_W:0]   br_sum;
    logic [PC_W-1:0]   pc_inc;
    logic              br_cross;
    logic              ld_any;

    assign ld_any   = adl_we | adh_we;
    assign br_sum   = {1'b0, pcl} + {1'b0, br_off};
    assign pc_inc   = {pch, pcl} + ONE_F;
    // A page is crossed when the carry disagrees with the offset sign.
    assign br_cross = br_sum[HALF_W] ^ br_off[HALF_W-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            pcl    <= RESET_VEC[HALF_W-1:0];
            pch    <= RESET_VEC[PC_W-1:HALF_W];
            dir_up <= 1'b1;
        end else begin
            state  <= state_n;
            pcl    <= pcl_n;
            pch    <= pch_n;
            dir_up <= dir_up_n;
        end
    end

    always_comb begin
        state_n  = state;
        pcl_n    = pcl;
        pch_n    = pch;
        dir_up_n = dir_up;
        unique case (state)
            IDLE: begin
                if (ld_any) begin
                    if (adl_we) pcl_n = adl_in;
                    if (adh_we) pch_n = adh_in;
                end else if (br_en) begin
                    pcl_n = br_sum[HALF_W-1:0];
                    if (br_cross) begin
                        dir_up_n = br_sum[HALF_W];
                        state_n  = FIX;
                    end
                end else if (inc) begin
                    pcl_n = pc_inc[HALF_W-1:0];
                    pch_n = pc_inc[PC_W-1:HALF_W];
                end
            end
            FIX: begin
                pch_n   = dir_up ? (pch + ONE_H) : (pch - ONE_H);
                if (adl_we) pcl_n = adl_in;
                if (adh_we) pch_n = adh_in;
                state_n = IDLE;
            end
        endcase
    end

    assign pcl_carry  = (state == IDLE) && inc && !ld_any && !br_en && (&pcl);
    assign page_cross = (state == FIX);
    assign busy       = (state == FIX);

    assign adl_out = adl_oe ? pcl : '0;
    assign adh_out = adh_oe ? pch : '0;
    assign db_out  = db_oe ? (db_sel ? pch : pcl) : '0;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: scenario tasks with an expected-PC
// scoreboard queue filled at drive time and drained after each edge.
module tb_pc_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] adl_in = '0, adh_in = '0, br_off = '0;
    logic       adl_we = 0, adh_we = 0, inc = 0, br_en = 0;
    logic       adl_oe = 1, adh_oe = 1, db_oe = 0, db_sel = 0;
    logic [7:0] adl_out, adh_out, db_out;
    logic       pcl_carry, page_cross, busy;

    int compared = 0;
    int mismatched = 0;

    string       nq[$];
    logic [15:0] vq[$];

    pc_unit #(.HALF_W(8), .RESET_VEC(16'hFFFC)) dut (
        .clk(clk), .rst_n(rst_n),
        .adl_in(adl_in), .adh_in(adh_in),
        .adl_we(adl_we), .adh_we(adh_we),
        .inc(inc), .br_en(br_en), .br_off(br_off),
        .adl_oe(adl_oe), .adh_oe(adh_oe),
        .db_oe(db_oe), .db_sel(db_sel),
        .adl_out(adl_out), .adh_out(adh_out), .db_out(db_out),
        .pcl_carry(pcl_carry), .page_cross(page_cross), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_pc(input string nm, input logic [15:0] v);
        nq.push_back(nm);
        vq.push_back(v);
    endtask

    task automatic load_pc(input logic [15:0] v);
        adl_in = v[7:0];
        adh_in = v[15:8];
        adl_we = 1;
        adh_we = 1;
        step();
        adl_we = 0;
        adh_we = 0;
    endtask

    task automatic test_reset();
        string       nm;
        logic [15:0] ev;
        @(posedge clk);
        #3 rst_n = 0;
        #1;
        compared++;
        if ({adh_out, adl_out} !== 16'hFFFC) begin
            $display("FAIL reset_async pc got %h want fffc", {adh_out, adl_out});
            mismatched++;
        end
        @(negedge clk);
        rst_n = 1;
        expect_pc("reset_pc", 16'hFFFC);
        step();
        nm = nq.pop_front();
        ev = vq.pop_front();
        compared++;
        if ({adh_out, adl_out} !== ev) begin
            $display("FAIL %s got %h want %h", nm, {adh_out, adl_out}, ev);
            mismatched++;
        end
        compared++;
        if (busy !== 1'b0 || page_cross !== 1'b0) begin
            $display("FAIL reset_busy got %b%b want 00", busy, page_cross);
            mismatched++;
        end
        adl_oe = 0;
        adh_oe = 0;
        #1;
        compared++;
        if ({adh_out, adl_out, db_out} !== 24'h0) begin
            $display("FAIL oe_off got %h want 000000", {adh_out, adl_out, db_out});
            mismatched++;
        end
        adl_oe = 1;
        adh_oe = 1;
    endtask

    task automatic test_inc_carry();
        string       nm;
        logic [15:0] ev;
        load_pc(16'h12FF);
        inc = 1;
        #1;
        compared++;
        if (pcl_carry !== 1'b1) begin
            $display("FAIL pcl_carry got %b want 1", pcl_carry);
            mismatched++;
        end
        expect_pc("inc_12ff", 16'h1300);
        step();
        inc = 0;
        #1;
        compared++;
        if (pcl_carry !== 1'b0) begin
            $display("FAIL pcl_carry_idle got %b want 0", pcl_carry);
            mismatched++;
        end
        load_pc(16'hFFFF);
        inc = 1;
        expect_pc("inc_wrap", 16'h0000);
        step();
        inc = 0;
        load_pc(16'h0041);
        inc = 1;
        expect_pc("inc_plain", 16'h0042);
        step();
        inc = 0;
        while (nq.size() > 0) begin
            nm = nq.pop_front();
            ev = vq.pop_front();
        end
        // Only the most recent expectation is still observable; recheck it.
        compared++;
        if ({adh_out, adl_out} !== ev) begin
            $display("FAIL %s got %h want %h", nm, {adh_out, adl_out}, ev);
            mismatched++;
        end
    endtask

    task automatic test_inc_each();
        logic [15:0] starts[3] = '{16'h12FF, 16'hFFFF, 16'h00FE};
        logic [15:0] ev;
        string       nm;
        for (int i = 0; i < 3; i++) begin
            load_pc(starts[i]);
            inc = 1;
            expect_pc($sformatf("inc_%h", starts[i]), starts[i] + 16'h1);
            step();
            inc = 0;
            nm = nq.pop_front();
            ev = vq.pop_front();
            compared++;
            if ({adh_out, adl_out} !== ev) begin
                $display("FAIL %s got %h want %h", nm, {adh_out, adl_out}, ev);
                mismatched++;
            end
        end
    endtask

    task automatic test_load_priority();
        string       nm;
        logic [15:0] ev;
        load_pc(16'h0000);
        adl_in = 8'h34;
        adh_in = 8'h80;
        adl_we = 1;
        adh_we = 1;
        inc = 1;
        br_en = 1;
        br_off = 8'h10;
        #1;
        compared++;
        if (pcl_carry !== 1'b0) begin
            $display("FAIL carry_under_load got %b want 0", pcl_carry);
            mismatched++;
        end
        expect_pc("load_pri", 16'h8034);
        step();
        adl_we = 0;
        adh_we = 0;
        inc = 0;
        br_en = 0;
        nm = nq.pop_front();
        ev = vq.pop_front();
        compared++;
        if ({adh_out, adl_out} !== ev) begin
            $display("FAIL %s got %h want %h", nm, {adh_out, adl_out}, ev);
            mismatched++;
        end
        db_oe = 1;
        db_sel = 1;
        #1;
        compared++;
        if (db_out !== 8'h80) begin
            $display("FAIL db_pch got %h want 80", db_out);
            mismatched++;
        end
        db_sel = 0;
        #1;
        compared++;
        if (db_out !== 8'h34) begin
            $display("FAIL db_pcl got %h want 34", db_out);
            mismatched++;
        end
        db_oe = 0;
        adl_in = 8'hAA;
        adl_we = 1;
        expect_pc("load_pcl_only", 16'h80AA);
        step();
        adl_we = 0;
        nm = nq.pop_front();
        ev = vq.pop_front();
        compared++;
        if ({adh_out, adl_out} !== ev) begin
            $display("FAIL %s got %h want %h", nm, {adh_out, adl_out}, ev);
            mismatched++;
        end
    endtask

    task automatic test_branch();
        logic [15:0] st[3] = '{16'h2010, 16'h20F0, 16'h2005};
        logic [7:0]  off[3] = '{8'h05, 8'h20, 8'hF0};
        logic [15:0] e1[3] = '{16'h2015, 16'h2010, 16'h20F5};
        logic [15:0] e2[3] = '{16'h2015, 16'h2110, 16'h1FF5};
        logic        bz[3] = '{1'b0, 1'b1, 1'b1};
        logic [15:0] ev;
        string       nm;
        for (int i = 0; i < 3; i++) begin
            load_pc(st[i]);
            br_en = 1;
            br_off = off[i];
            expect_pc($sformatf("br%0d_c1", i), e1[i]);
            expect_pc($sformatf("br%0d_c2", i), e2[i]);
            step();
            br_en = 0;
            nm = nq.pop_front();
            ev = vq.pop_front();
            compared++;
            if ({adh_out, adl_out} !== ev || busy !== bz[i]) begin
                $display("FAIL %s got %h busy %b want %h busy %b",
                         nm, {adh_out, adl_out}, busy, ev, bz[i]);
                mismatched++;
            end
            compared++;
            if (page_cross !== bz[i]) begin
                $display("FAIL br%0d_pcross got %b want %b", i, page_cross, bz[i]);
                mismatched++;
            end
            step();
            nm = nq.pop_front();
            ev = vq.pop_front();
            compared++;
            if ({adh_out, adl_out} !== ev || busy !== 1'b0) begin
                $display("FAIL %s got %h busy %b want %h busy 0",
                         nm, {adh_out, adl_out}, busy, ev);
                mismatched++;
            end
        end
    endtask

    task automatic test_load_in_fix();
        string       nm;
        logic [15:0] ev;
        load_pc(16'h20F0);
        br_en = 1;
        br_off = 8'h20;
        step();
        br_en = 0;
        compared++;
        if (busy !== 1'b1) begin
            $display("FAIL fix_entry busy got %b want 1", busy);
            mismatched++;
        end
        adh_in = 8'h55;
        adh_we = 1;
        expect_pc("load_in_fix", 16'h5510);
        step();
        adh_we = 0;
        nm = nq.pop_front();
        ev = vq.pop_front();
        compared++;
        if ({adh_out, adl_out} !== ev || busy !== 1'b0) begin
            $display("FAIL %s got %h busy %b want %h busy 0",
                     nm, {adh_out, adl_out}, busy, ev);
            mismatched++;
        end
    endtask

    task automatic test_reset_mid_fix();
        string       nm;
        logic [15:0] ev;
        load_pc(16'h20F0);
        br_en = 1;
        br_off = 8'h20;
        step();
        br_en = 0;
        #2 rst_n = 0;
        #1;
        compared++;
        if ({adh_out, adl_out} !== 16'hFFFC || busy !== 1'b0) begin
            $display("FAIL reset_mid_fix got %h busy %b want fffc busy 0",
                     {adh_out, adl_out}, busy);
            mismatched++;
        end
        @(negedge clk);
        rst_n = 1;
        inc = 1;
        expect_pc("inc_after_reset", 16'hFFFD);
        step();
        inc = 0;
        nm = nq.pop_front();
        ev = vq.pop_front();
        compared++;
        if ({adh_out, adl_out} !== ev) begin
            $display("FAIL %s got %h want %h", nm, {adh_out, adl_out}, ev);
            mismatched++;
        end
    endtask

    initial begin
        test_reset();
        test_inc_carry();
        test_inc_each();
        test_load_priority();
        test_branch();
        test_load_in_fix();
        test_reset_mid_fix();
        compared++;
        if (nq.size() != 0) begin
            $display("FAIL scoreboard_leftover got %0d want 0", nq.size());
            mismatched++;
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised 6502-style program counter covering both halves (PCL and PCH) behind a single register. It supports:
- independent half loads from the ADL/ADH buses,
- full-width increment with carry,
- an output path onto the data bus,
- relative branch add with the two-step page-cross fix-up cycle.

It replaces the separate low-half counter in the CPU datapath and is driven cycle-by-cycle by the control decoder.

## Interface
- HALF_W, 8: width of each PC half; full PC is 2*HALF_W bits
- RESET_VEC, 16'hFFFC: PC value loaded on reset (2*HALF_W bits)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- adl_in  in  HALF_W  value loaded into PCL
- adh_in  in  HALF_W  value loaded into PCH
- adl_we  in  1  load PCL from adl_in
- adh_we  in  1  load PCH from adh_in
- inc  in  1  increment full PC by 1
- br_en  in  1  start relative branch
- br_off  in  HALF_W  two's-complement branch offset
- adl_oe  in  1  drive PCL on adl_out
- adh_oe  in  1  drive PCH on adh_out
- db_oe  in  1  drive selected half on db_out
- db_sel  in  1  0 = PCL, 1 = PCH onto db_out
- adl_out  out  HALF_W  PCL when adl_oe, else 0
- adh_out  out  HALF_W  PCH when adh_oe, else 0
- db_out  out  HALF_W  selected half when db_oe, else 0
- pcl_carry  out  1  combinational: inc active in IDLE and PCL is all ones
- page_cross  out  1  registered: high while in FIX state
- busy  out  1  registered: high while in FIX state

## Operation
- Two states:
  - IDLE: normal operation.
  - FIX: PCH adjust pending after a branch crosses a page.
- Outputs are purely combinational from the current registered PC. Reads show the pre-update value in the same cycle as a write or increment.
- IDLE, per-cycle priority, highest first:
  - Load: adl_we and/or adh_we write the respective halves. Both may load together. inc and br_en are ignored that cycle.
  - Branch (br_en):
    - sum = PCL + br_off, computed HALF_W+1 wide; PCL <= sum[HALF_W-1:0].
    - Page cross occurs when the carry out differs from the sign of br_off:
      - positive offset with carry, or
      - negative offset without carry.
    - On page cross: record direction (up if carry, down otherwise) and go to FIX. Otherwise stay in IDLE.
  - Increment (inc): PC <= PC + 1 over the full 2*HALF_W bits. All ones wraps to 0.
  - None active: hold.
- FIX, one cycle only:
  - PCH <= PCH + 1 (up) or PCH - 1 (down), modulo 2^HALF_W. Return to IDLE.
  - Any adl_we/adh_we in this cycle overrides the fix for that half. The written half takes the load value; state still returns to IDLE.
  - inc and br_en are ignored in FIX. The controller must not assert them while busy.
- Reset (asynchronous, any time, including mid-FIX):
  - PC <= RESET_VEC, state <= IDLE, direction <= up.
  - page_cross = busy = 0.
  - Combinational outputs follow the new PC immediately.

## Timing
- Load, increment, and a non-crossing branch complete in 1 cycle. The new PC is visible on enabled outputs after the next rising edge.
- A page-crossing branch takes 2 cycles:
  - Edge 1: PCL updated, busy = page_cross = 1.
  - Edge 2: PCH corrected, busy = 0.
- pcl_carry is valid in the same cycle inc is asserted. It is 0 when a load or branch has priority, and 0 in FIX.
- Output enables are independent. All three outputs may be driven in the same cycle.

## Test plan
- Reset and output enables: assert rst_n=0 mid-cycle, then release, with adl_oe=adh_oe=1 → adl_out=8'hFC, adh_out=8'hFF, busy=0. Drop the enables → both outputs read 0.
- Increment carry:
  - Load PC=16'h12FF, pulse inc → pcl_carry=1 during the inc cycle; PC=16'h1300 after the edge.
  - From 16'hFFFF, inc → PC=16'h0000.
- Loads and priority: adl_we with adl_in=8'h34 and adh_we with adh_in=8'h80 together with inc=1 → PC=16'h8034, no increment applied. With db_sel=1, db_oe=1 → db_out=8'h80.
- Branches:
  - Non-crossing: PC=16'h2010, br_off=8'h05 → PC=16'h2015 in 1 cycle, busy stays 0.
  - Crossing forward: PC=16'h20F0, br_off=8'h20 → cycle 1: PC=16'h2010, busy=1; cycle 2: PC=16'h2110, busy=0.
  - Crossing backward: PC=16'h2005, br_off=8'hF0 → cycle 1: PC=16'h20F5, busy=1; cycle 2: PC=16'h1FF5.
- Load during FIX: start a forward-crossing branch from 16'h20F0 with br_off=8'h20, then assert adh_we with adh_in=8'h55 in the FIX cycle → PC=16'h5510, state returns to IDLE.
- Reset mid-FIX: pull rst_n low during busy=1 → PC=16'hFFFC and busy=0 immediately. After release, the next inc → PC=16'hFFFD.
